// File: rtl/pmem_arbiter_n_pkg.sv
// Shared types for the physical-memory arbiter: cache line defaults and
// arbitration FSM / mode encodings.
package cache_types;
  localparam int ADDR_W_DEFAULT = 32;
  localparam int LINE_W_DEFAULT = 256;
endpackage

package arb_types;
  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_BUSY = 2'd1,
    A_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  // Successor of a port index, wrapping at the port count.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction
endpackage

// File: rtl/pmem_arbiter_n_picker.sv
// Combinational winner selection over the request vector, either fixed
// priority (port 0 first) or round-robin starting at rr_ptr.
module arb_picker
  import arb_types::*;
#(
  parameter int  NUM_PORTS = 2,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  input  arb_mode_t            mode,
  output logic                 valid,
  output logic [IDX_W-1:0]     index
);
  int cand;

  // Walk from lowest to highest priority; the last requesting hit wins.
  always_comb begin
    valid = |req;
    index = '0;
    cand  = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = (mode == ARB_FIXED) ? k : (int'(rr_ptr) + k) % NUM_PORTS;
      if (req[cand]) begin
        index = IDX_W'(cand);
      end else begin
        index = index;
      end
    end
  end
endmodule

// File: rtl/pmem_arbiter_n.sv
// N-port cache-line arbiter in front of a single physical memory port.
// One transaction at a time: IDLE picks, BUSY drives memory, RESP pulses.
module pmem_arbiter_n
  import arb_types::*;
#(
  parameter int        NUM_PORTS = 2,
  parameter int        ADDR_W    = cache_types::ADDR_W_DEFAULT,
  parameter int        LINE_W    = cache_types::LINE_W_DEFAULT,
  parameter arb_mode_t ARB_MODE  = ARB_RR,
  localparam int       IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS-1:0][LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]                req_rdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_W-1:0]                pmem_address,
  output logic [LINE_W-1:0]                pmem_wdata,
  input  logic [LINE_W-1:0]                pmem_rdata,
  input  logic                             pmem_resp,
  output logic [IDX_W-1:0]                 grant_id
);
  arb_state_t           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_PORTS-1:0] req_any;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_index;

  assign req_any = req_read | req_write;

  arb_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req   (req_any),
    .rr_ptr(rr_ptr),
    .mode  (ARB_MODE),
    .valid (pick_valid),
    .index (pick_index)
  );

  // Arbitration FSM; pmem_read/pmem_write double as the latched operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= A_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      req_resp     <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      req_rdata    <= '0;
    end else begin
      case (state)
        A_IDLE: begin
          req_resp <= '0;
          if (pick_valid) begin
            grant_id     <= pick_index;
            pmem_address <= req_address[pick_index];
            pmem_wdata   <= req_wdata[pick_index];
            pmem_write   <= req_write[pick_index];
            pmem_read    <= ~req_write[pick_index];
            state        <= A_BUSY;
          end else begin
            state <= A_IDLE;
          end
        end
        A_BUSY: begin
          if (pmem_resp) begin
            if (pmem_read) begin
              req_rdata <= pmem_rdata;
            end else begin
              req_rdata <= req_rdata;
            end
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            req_resp   <= NUM_PORTS'(1'b1) << grant_id;
            rr_ptr     <= IDX_W'(wrap_inc(32'(grant_id), NUM_PORTS));
            state      <= A_RESP;
          end else begin
            state <= A_BUSY;
          end
        end
        // Dead cycle: the finished port drops its request before the next pick.
        A_RESP: begin
          req_resp <= '0;
          state    <= A_IDLE;
        end
        default: begin
          req_resp   <= '0;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
          state      <= A_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pmem_arbiter_n.sv
// Bench: three arbiter instances (2-port RR, 4-port RR, 4-port fixed) checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_pmem_arbiter_n;
  import arb_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]            rd_a   [3];
  logic [3:0]            wr_a   [3];
  logic [3:0][31:0]      addr_a [3];
  logic [3:0][255:0]     wd_a   [3];
  logic [255:0]          prd_a  [3];
  logic                  presp_a[3];
  logic [255:0]          rdata_o[3];
  logic [3:0]            resp_o [3];
  logic                  pr_o   [3];
  logic                  pw_o   [3];
  logic [31:0]           pa_o   [3];
  logic [255:0]          pwd_o  [3];
  logic [1:0]            gid_o  [3];

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int        NP = (g == 0) ? 2 : 4;
    localparam int        IW = $clog2(NP);
    localparam arb_mode_t MD = (g == 2) ? ARB_FIXED : ARB_RR;
    logic [NP-1:0] resp_w;
    logic [IW-1:0] gid_w;
    pmem_arbiter_n #(.NUM_PORTS(NP), .ADDR_W(32), .LINE_W(256), .ARB_MODE(MD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_read    (rd_a[g][NP-1:0]),
      .req_write   (wr_a[g][NP-1:0]),
      .req_address (addr_a[g][NP-1:0]),
      .req_wdata   (wd_a[g][NP-1:0]),
      .req_rdata   (rdata_o[g]),
      .req_resp    (resp_w),
      .pmem_read   (pr_o[g]),
      .pmem_write  (pw_o[g]),
      .pmem_address(pa_o[g]),
      .pmem_wdata  (pwd_o[g]),
      .pmem_rdata  (prd_a[g]),
      .pmem_resp   (presp_a[g]),
      .grant_id    (gid_w)
    );
    assign resp_o[g] = 4'(resp_w);
    assign gid_o[g]  = 2'(gid_w);
  end

  int n_vec = 0;
  int n_err = 0;

  // requester / memory environment
  int         want [3][4];
  logic [1:0] op   [3][4];
  int         lat  [3];
  int         cnt  [3];
  logic       stray[3];

  // transaction-level model
  logic         m_busy[3], m_cool[3], m_wr[3];
  int           m_gid[3], m_ptr[3];
  logic [31:0]  m_addr[3];
  logic [255:0] m_wd[3], m_rdata[3];

  int glog[3][16];
  int gcnt[3];
  int rdhi;

  task automatic chk(input string nm, input int g, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0h expected %0h", nm, g, act, exp);
    end
  endtask

  function automatic int np(input int g);
    return (g == 0) ? 2 : 4;
  endfunction

  function automatic int pick(input int g, input logic [3:0] rq);
    int w = -1;
    int c;
    for (int j = 0; j < np(g); j++) begin
      c = (g == 2) ? j : (m_ptr[g] + j) % np(g);
      if (rq[c] && w < 0) w = c;
    end
    return w;
  endfunction

  task automatic mreset(input int g);
    m_busy[g] = 1'b0; m_cool[g] = 1'b0; m_wr[g] = 1'b0;
    m_gid[g] = 0; m_ptr[g] = 0; m_addr[g] = '0; m_wd[g] = '0; m_rdata[g] = '0;
  endtask

  task automatic mstep(input int g);
    int w;
    if (m_cool[g]) begin
      m_cool[g] = 1'b0;
    end else if (m_busy[g]) begin
      if (presp_a[g]) begin
        m_busy[g] = 1'b0;
        m_cool[g] = 1'b1;
        if (!m_wr[g]) m_rdata[g] = prd_a[g];
        m_ptr[g] = (m_gid[g] + 1) % np(g);
      end
    end else begin
      w = pick(g, rd_a[g] | wr_a[g]);
      if (w >= 0) begin
        m_gid[g] = w; m_busy[g] = 1'b1; m_wr[g] = wr_a[g][w];
        m_addr[g] = addr_a[g][w]; m_wd[g] = wd_a[g][w];
      end
    end
  endtask

  // per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) mreset(g);
      chk("pmem_read", g, 256'(pr_o[g]), 256'(m_busy[g] & ~m_wr[g]));
      chk("pmem_write", g, 256'(pw_o[g]), 256'(m_busy[g] & m_wr[g]));
      chk("pmem_address", g, 256'(pa_o[g]), 256'(m_addr[g]));
      chk("pmem_wdata", g, pwd_o[g], m_wd[g]);
      chk("req_resp", g, 256'(resp_o[g]), 256'(m_cool[g] ? (4'b0001 << m_gid[g]) : 4'b0000));
      chk("req_rdata", g, rdata_o[g], m_rdata[g]);
      chk("grant_id", g, 256'(gid_o[g]), 256'(m_gid[g]));
      for (int p = 0; p < 4; p++) begin
        if (resp_o[g][p]) begin
          if (gcnt[g] < 16) glog[g][gcnt[g]] = p;
          gcnt[g]++;
        end
      end
      if (g == 0 && pr_o[0]) rdhi++;
      if (rst_n) mstep(g);
    end
  end

  task automatic lines(input int g);
    for (int p = 0; p < 4; p++) begin
      rd_a[g][p] = (want[g][p] > 0) && op[g][p][0];
      wr_a[g][p] = (want[g][p] > 0) && op[g][p][1];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        cnt[g] = 0; presp_a[g] = 1'b0;
      end else if (pr_o[g] || pw_o[g]) begin
        cnt[g]++;
        presp_a[g] = (cnt[g] == lat[g]);
        if (cnt[g] == lat[g]) begin
          cnt[g] = 0;
          if (g != 0) prd_a[g] = {8{$urandom()}};
        end
      end else begin
        cnt[g] = 0; presp_a[g] = stray[g];
      end
      for (int p = 0; p < 4; p++)
        if (resp_o[g][p] && want[g][p] > 0) want[g][p]--;
      lines(g);
    end
  endtask

  task automatic set_req(input int g, input int p, input logic [1:0] o, input logic [31:0] a,
                         input logic [255:0] d, input int c);
    op[g][p] = o; addr_a[g][p] = a; wd_a[g][p] = d; want[g][p] = c;
    lines(g);
  endtask

  function automatic bit pending(input int g);
    bit b = 1'b0;
    for (int p = 0; p < 4; p++) if (want[g][p] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_done(input int g, input int bound);
    int k = 0;
    while (pending(g) && k < bound) begin step(); k++; end
    chk("completion_timeout", g, 256'(k < bound), 256'(1));
    step(); step();
  endtask

  task automatic wait_cmd(input int g, input int bound);
    int k = 0;
    while (!(pr_o[g] || pw_o[g]) && k < bound) begin step(); k++; end
    chk("command_timeout", g, 256'(k < bound), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout inst0: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base;
    int exp5[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp6[3] = '{1, 1, 3};
    int per[4];
    for (int g = 0; g < 3; g++) begin
      rd_a[g] = '0; wr_a[g] = '0; addr_a[g] = '0; wd_a[g] = '0;
      prd_a[g] = '0; presp_a[g] = 1'b0; lat[g] = 3; cnt[g] = 0; stray[g] = 1'b0; gcnt[g] = 0;
      for (int p = 0; p < 4; p++) begin want[g][p] = 0; op[g][p] = 2'b00; end
    end
    rdhi = 0;
    repeat (3) step();
    chk("reset_rdata", 0, rdata_o[0], 256'(0));
    chk("reset_grant", 1, 256'(gid_o[1]), 256'(0));
    rst_n = 1'b1;
    step();

    // single read, 5-cycle memory latency
    lat[0] = 5; prd_a[0] = {32{8'hA5}}; rdhi = 0;
    set_req(0, 0, 2'b01, 32'h0000_1000, '0, 1);
    wait_done(0, 60);
    chk("sc1_read_cycles", 0, 256'(rdhi), 256'(5));
    chk("sc1_rdata", 0, rdata_o[0], {32{8'hA5}});
    chk("sc1_resp_cycles", 0, 256'(gcnt[0]), 256'(1));
    chk("sc1_resp_port", 0, 256'(glog[0][0]), 256'(0));

    // read+write together: write wins
    lat[0] = 3; prd_a[0] = {32{8'h3C}};
    set_req(0, 1, 2'b11, 32'h0000_2000, {32{8'h5A}}, 1);
    wait_cmd(0, 10);
    chk("sc2_pmem_write", 0, 256'(pw_o[0]), 256'(1));
    chk("sc2_pmem_read", 0, 256'(pr_o[0]), 256'(0));
    chk("sc2_wdata", 0, pwd_o[0], {32{8'h5A}});
    chk("sc2_address", 0, 256'(pa_o[0]), 256'(32'h0000_2000));
    wait_done(0, 40);
    chk("sc2_rdata_kept", 0, rdata_o[0], {32{8'hA5}});

    // stray memory response while idle
    base = gcnt[0];
    prd_a[0] = {32{8'hFF}}; stray[0] = 1'b1;
    step();
    stray[0] = 1'b0;
    repeat (3) step();
    chk("sc3_no_resp", 0, 256'(gcnt[0]), 256'(base));
    chk("sc3_rdata_kept", 0, rdata_o[0], {32{8'hA5}});

    // reset mid-transaction, then restart with pointer back at 0
    set_req(0, 0, 2'b01, 32'h0000_3000, '0, 1);
    wait_done(0, 40);
    lat[0] = 20;
    set_req(0, 0, 2'b01, 32'h0000_4000, '0, 1);
    set_req(0, 1, 2'b01, 32'h0000_5000, '0, 1);
    wait_cmd(0, 10);
    chk("sc4_rr_grant", 0, 256'(gid_o[0]), 256'(1));
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("sc4_reset_read", 0, 256'(pr_o[0]), 256'(0));
    chk("sc4_reset_resp", 0, 256'(resp_o[0]), 256'(0));
    repeat (3) step();
    lat[0] = 3; base = gcnt[0];
    rst_n = 1'b1;
    wait_cmd(0, 10);
    chk("sc4_first_grant", 0, 256'(gid_o[0]), 256'(0));
    wait_done(0, 60);
    chk("sc4_resp_count", 0, 256'(gcnt[0] - base), 256'(2));
    chk("sc4_order0", 0, 256'(glog[0][base]), 256'(0));
    chk("sc4_order1", 0, 256'(glog[0][base+1]), 256'(1));

    // 4-port round-robin, two rounds of reads
    lat[1] = 2;
    for (int p = 0; p < 4; p++) set_req(1, p, 2'b01, 32'h100 * (p + 1), {8{32'(p)}}, 2);
    wait_done(1, 200);
    chk("sc5_resp_total", 1, 256'(gcnt[1]), 256'(8));
    for (int i = 0; i < 8; i++) chk("sc5_grant_order", 1, 256'(glog[1][i]), 256'(exp5[i]));
    for (int p = 0; p < 4; p++) per[p] = 0;
    for (int i = 0; i < 4; i++) per[glog[1][i]]++;
    for (int p = 0; p < 4; p++) chk("sc5_one_per_round", 1, 256'(per[p]), 256'(1));

    // 4-port fixed priority, port 1 re-requests
    lat[2] = 2;
    set_req(2, 1, 2'b01, 32'h0000_0A00, '0, 2);
    set_req(2, 3, 2'b10, 32'h0000_0C00, {32{8'hC3}}, 1);
    wait_done(2, 100);
    chk("sc6_resp_total", 2, 256'(gcnt[2]), 256'(3));
    for (int i = 0; i < 3; i++) chk("sc6_grant_order", 2, 256'(glog[2][i]), 256'(exp6[i]));

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pmem_arbiter_n.md
PMEM_ARBITER_N -- requirements
Module: pmem_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2; number of cache-line requester channels, legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32; physical address width.
REQ-003 SHALL have parameter LINE_W, default 256; cache line width in bits.
REQ-004 SHALL have parameter ARB_MODE, default ARB_RR; ARB_FIXED gives port 0 highest priority, ARB_RR gives round-robin.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 req_read  in  NUM_PORTS  per-port line read request, held until that port's req_resp.
REQ-009 req_write  in  NUM_PORTS  per-port line write request, held until that port's req_resp.
REQ-010 req_address  in  NUM_PORTS x ADDR_W  per-port line address.
REQ-011 req_wdata  in  NUM_PORTS x LINE_W  per-port write line.
REQ-012 req_rdata  out  LINE_W  registered read line, shared by all ports.
REQ-013 req_resp  out  NUM_PORTS  one-cycle per-port completion pulse.
REQ-014 pmem_read / pmem_write  out  1 each  physical memory command.
REQ-015 pmem_address  out  ADDR_W; pmem_wdata  out  LINE_W; both registered.
REQ-016 pmem_rdata  in  LINE_W; pmem_resp  in  1  memory completion.
REQ-017 grant_id  out  $clog2(NUM_PORTS)  index of the port currently owning memory.

Function
REQ-018 SHALL implement FSM A_IDLE -> A_BUSY -> A_RESP -> A_IDLE.
REQ-019 A_IDLE: if any port has req_read or req_write, SHALL pick a winner, latch its index, address, wdata and op, and move to A_BUSY next edge; otherwise stay.
REQ-020 A_BUSY: SHALL hold pmem_read or pmem_write high with the latched address/data, and stay until pmem_resp=1.
REQ-021 On pmem_resp in A_BUSY, SHALL register pmem_rdata into req_rdata on reads and move to A_RESP.
REQ-022 A_RESP: SHALL assert req_resp[grant_id] for exactly one cycle, deassert pmem_read/pmem_write, and return to A_IDLE.
REQ-023 Latency: request visible in A_IDLE cycle t gives the pmem command at t+1; pmem_resp at cycle k gives req_resp at k+1.
REQ-024 ARB_FIXED: the lowest-indexed requesting port SHALL win.
REQ-025 ARB_RR: the first requesting port at or after rr_ptr, wrapping modulo NUM_PORTS, SHALL win.
REQ-026 ARB_RR pointer: on entry to A_RESP, rr_ptr SHALL become (grant_id+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
REQ-027 If a port has both req_read and req_write high, the write SHALL be issued.
REQ-028 pmem_resp in A_IDLE or A_RESP SHALL be ignored.
REQ-029 Request changes on any port during A_BUSY/A_RESP SHALL NOT affect the transaction in flight.
REQ-030 The A_RESP dead cycle SHALL guarantee that a completed port's still-high request is not re-granted.
REQ-031 req_rdata SHALL hold its last value until the next read completion.

Reset
REQ-032 While rst_n=0, regardless of clk: state=A_IDLE, rr_ptr=0, grant_id=0, req_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, req_rdata=0.
REQ-033 Reset mid-transaction SHALL abort it with no req_resp pulse; after deassertion, arbitration SHALL restart from A_IDLE with rr_ptr=0.

Structure
REQ-034 Package arb_types SHALL define arb_state_t {A_IDLE, A_BUSY, A_RESP} and arb_mode_t {ARB_FIXED, ARB_RR}, alongside cache_types.
REQ-035 Winner selection SHALL be a combinational sub-module arb_picker (inputs: request vector, rr_ptr, mode; outputs: valid, index).
REQ-036 Per-port buses SHALL be packed 2-D arrays indexed [NUM_PORTS-1:0].

Verification
REQ-037 NUM_PORTS=2, RR: port0 read 0x0000_1000; memory resp after 5 cycles with 0xA5..A5 -> pmem_read high 5 cycles, req_rdata=0xA5..A5, req_resp=2'b01 for 1 cycle.
REQ-038 NUM_PORTS=4, RR: all four hold reads -> grants in order 0,1,2,3,0; each port gets exactly one req_resp per round.
REQ-039 NUM_PORTS=4, FIXED: ports 1 and 3 request together; port 1 re-requests after resp -> port 1 is served twice before port 3.
REQ-040 Port1 asserts read and write together at 0x0000_2000 with wdata 0x5A..5A -> pmem_write=1, pmem_read=0, pmem_wdata=0x5A..5A.
REQ-041 rst_n low during A_BUSY -> pmem_read=0 and req_resp=0 immediately; with a request still held after release, first grant is port 0.
REQ-042 Stray pmem_resp in A_IDLE -> no req_resp pulse and req_rdata unchanged.
